// File: rtl/stall_aware_control.sv
// Multi-cycle core control FSM: fetch/execute/memory sequencing with stall
// timeouts, prioritized sticky halt causes and a retired-instruction counter.
module stall_aware_control #(
  parameter int MAX_WAIT    = 15,
  parameter int NUM_ERR     = 4,
  parameter int COUNT_W     = 32,
  parameter int ECALL_HALTS = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [6:0]         opcode,
  input  logic [2:0]         funct3,
  input  logic [NUM_ERR-1:0] errorFlags,
  input  logic               fetchReady,
  input  logic               memReady,
  output logic               fetchReq,
  output logic               memReq,
  output logic [1:0]         memoryMode,
  output logic               rdWriteEnable,
  output logic [1:0]         rdSource,
  output logic               opImm,
  output logic               programCounterWriteEnable,
  output logic               halted,
  output logic [2:0]         haltCause,
  output logic [COUNT_W-1:0] retiredCount
);

  typedef enum logic [2:0] {FETCH, EXECUTE, MEM_PRELOAD, MEM_ACCESS, HALT} state_t;

  localparam logic [4:0] OP_LOAD    = 5'b00000;
  localparam logic [4:0] OP_MISCMEM = 5'b00011;
  localparam logic [4:0] OP_OPIMM   = 5'b00100;
  localparam logic [4:0] OP_AUIPC   = 5'b00101;
  localparam logic [4:0] OP_STORE   = 5'b01000;
  localparam logic [4:0] OP_OP      = 5'b01100;
  localparam logic [4:0] OP_LUI     = 5'b01101;
  localparam logic [4:0] OP_BRANCH  = 5'b11000;
  localparam logic [4:0] OP_JALR    = 5'b11001;
  localparam logic [4:0] OP_JAL     = 5'b11011;
  localparam logic [4:0] OP_SYSTEM  = 5'b11100;

  localparam logic [2:0] CAUSE_ECALL   = 3'd1;
  localparam logic [2:0] CAUSE_BADOP   = 3'd2;
  localparam logic [2:0] CAUSE_BADLOW  = 3'd3;
  localparam logic [2:0] CAUSE_ERROR   = 3'd4;
  localparam logic [2:0] CAUSE_TIMEOUT = 3'd5;

  state_t       state, nextState;
  logic [7:0]   waitCount;
  logic         memIsLoad, nextMemIsLoad;
  logic [2:0]   haltCauseReg, nextCause;
  logic         anyError, waitExpired;

  assign anyError    = |errorFlags;
  // The MAX_WAIT-th consecutive stalled cycle is the one that times out.
  assign waitExpired = (waitCount >= 8'(MAX_WAIT - 1));
  assign halted      = (state == HALT);
  assign haltCause   = haltCauseReg;

  always_comb begin
    nextState                 = state;
    nextCause                 = 3'd0;
    nextMemIsLoad             = memIsLoad;
    fetchReq                  = 1'b0;
    memReq                    = 1'b0;
    memoryMode                = 2'd0;
    rdWriteEnable             = 1'b0;
    rdSource                  = 2'd0;
    opImm                     = 1'b0;
    programCounterWriteEnable = 1'b0;
    case (state)
      FETCH: begin
        fetchReq = 1'b1;
        if (fetchReady) begin
          nextState = EXECUTE;
        end else if (waitExpired) begin
          nextState = HALT;
          nextCause = CAUSE_TIMEOUT;
        end
      end
      EXECUTE: begin
        nextState = FETCH;
        if (anyError) begin
          nextState = HALT;
          nextCause = CAUSE_ERROR;
        end else if (opcode[1:0] != 2'b11) begin
          nextState = HALT;
          nextCause = CAUSE_BADLOW;
        end else begin
          case (opcode[6:2])
            OP_LUI, OP_AUIPC: begin
              rdWriteEnable             = 1'b1;
              rdSource                  = 2'd2;
              programCounterWriteEnable = 1'b1;
            end
            OP_JAL, OP_JALR: begin
              rdWriteEnable             = 1'b1;
              rdSource                  = 2'd3;
              programCounterWriteEnable = 1'b1;
            end
            OP_OPIMM, OP_OP: begin
              rdWriteEnable             = 1'b1;
              rdSource                  = 2'd1;
              opImm                     = (opcode[6:2] == OP_OPIMM);
              programCounterWriteEnable = 1'b1;
            end
            OP_BRANCH, OP_MISCMEM: programCounterWriteEnable = 1'b1;
            OP_LOAD: begin
              nextState     = MEM_ACCESS;
              nextMemIsLoad = 1'b1;
            end
            OP_STORE: begin
              // Only full-word stores skip the read-modify-write preload.
              nextState     = (funct3 == 3'b010) ? MEM_ACCESS : MEM_PRELOAD;
              nextMemIsLoad = 1'b0;
            end
            OP_SYSTEM: begin
              if (funct3 != 3'b000) begin
                nextState = HALT;
                nextCause = CAUSE_BADOP;
              end else if (ECALL_HALTS != 0) begin
                nextState = HALT;
                nextCause = CAUSE_ECALL;
              end else begin
                programCounterWriteEnable = 1'b1;
              end
            end
            default: begin
              nextState = HALT;
              nextCause = CAUSE_BADOP;
            end
          endcase
        end
      end
      MEM_PRELOAD: begin
        memReq     = 1'b1;
        memoryMode = 2'd2;
        if (anyError) begin
          nextState = HALT;
          nextCause = CAUSE_ERROR;
        end else if (memReady) begin
          nextState = MEM_ACCESS;
        end else if (waitExpired) begin
          nextState = HALT;
          nextCause = CAUSE_TIMEOUT;
        end
      end
      MEM_ACCESS: begin
        memReq     = 1'b1;
        memoryMode = memIsLoad ? 2'd1 : 2'd3;
        if (anyError) begin
          nextState = HALT;
          nextCause = CAUSE_ERROR;
        end else if (memReady) begin
          nextState                 = FETCH;
          programCounterWriteEnable = 1'b1;
          rdWriteEnable             = memIsLoad;
        end else if (waitExpired) begin
          nextState = HALT;
          nextCause = CAUSE_TIMEOUT;
        end
      end
      HALT:    nextState = HALT;
      default: nextState = FETCH;
    endcase
    // Reset wins over everything, including a completing memory access.
    if (reset) begin
      fetchReq                  = 1'b0;
      memReq                    = 1'b0;
      rdWriteEnable             = 1'b0;
      programCounterWriteEnable = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= FETCH;
      waitCount    <= '0;
      haltCauseReg <= 3'd0;
      memIsLoad    <= 1'b0;
      retiredCount <= '0;
    end else begin
      state     <= nextState;
      memIsLoad <= nextMemIsLoad;
      if (nextState != state) begin
        waitCount <= '0;
      end else if (state == FETCH || state == MEM_PRELOAD || state == MEM_ACCESS) begin
        waitCount <= waitCount + 8'd1;
      end
      if (nextState == HALT && state != HALT) begin
        haltCauseReg <= nextCause;
      end
      if (programCounterWriteEnable) begin
        retiredCount <= retiredCount + COUNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_stall_aware_control.sv
// Directed bench for stall_aware_control: two parameterisations share stimulus
// and are compared every cycle against an instruction-level behavioural model.
module tb_stall_aware_control;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [3:0] errorFlags;
  logic       fetchReady, memReady;

  logic       frO [2];
  logic       mrO [2];
  logic [1:0] mmO [2];
  logic       weO [2];
  logic [1:0] srcO[2];
  logic       immO[2];
  logic       pcO [2];
  logic       hO  [2];
  logic [2:0] hcO [2];
  logic [3:0]  cntA;
  logic [31:0] cntB;

  stall_aware_control #(.MAX_WAIT(4), .NUM_ERR(4), .COUNT_W(4), .ECALL_HALTS(1)) dutA (
    .clock(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .errorFlags(errorFlags),
    .fetchReady(fetchReady), .memReady(memReady), .fetchReq(frO[0]), .memReq(mrO[0]),
    .memoryMode(mmO[0]), .rdWriteEnable(weO[0]), .rdSource(srcO[0]), .opImm(immO[0]),
    .programCounterWriteEnable(pcO[0]), .halted(hO[0]), .haltCause(hcO[0]), .retiredCount(cntA));

  stall_aware_control #(.MAX_WAIT(15), .NUM_ERR(4), .COUNT_W(32), .ECALL_HALTS(0)) dutB (
    .clock(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .errorFlags(errorFlags),
    .fetchReady(fetchReady), .memReady(memReady), .fetchReq(frO[1]), .memReq(mrO[1]),
    .memoryMode(mmO[1]), .rdWriteEnable(weO[1]), .rdSource(srcO[1]), .opImm(immO[1]),
    .programCounterWriteEnable(pcO[1]), .halted(hO[1]), .haltCause(hcO[1]), .retiredCount(cntB));

  typedef struct packed {
    logic        fetchReq;
    logic        memReq;
    logic [1:0]  memoryMode;
    logic        rdWE;
    logic [1:0]  rdSource;
    logic        opImm;
    logic        pcWE;
    logic        halted;
    logic [2:0]  haltCause;
    logic [31:0] retired;
  } outs_t;

  localparam int P_FETCH = 0, P_EXEC = 1, P_PRE = 2, P_ACC = 3, P_HALT = 4;
  localparam int K_WRITE = 0, K_PC = 1, K_LOAD = 2, K_SW = 3, K_STPRE = 4,
                 K_ECALL = 5, K_BADLOW = 6, K_BAD = 7;

  int          maxW      [2] = '{4, 15};
  bit          ecallHalts[2] = '{1'b1, 1'b0};
  logic [31:0] cntMask   [2] = '{32'hF, 32'hFFFF_FFFF};

  int          mPhase[2], mWait[2], mCause[2];
  logic [31:0] mCount[2];
  bit          mLoad[2];
  int          pPhase[2], pWait[2], pCause[2];
  logic [31:0] pCount[2];
  bit          pLoad[2];
  bit          modelValid = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  function automatic int classify(input logic [6:0] op, input logic [2:0] f3,
                                  output logic [1:0] src, output logic imm);
    src = 2'd0;
    imm = 1'b0;
    if (op[1:0] != 2'b11) return K_BADLOW;
    case (op)
      7'b0110111, 7'b0010111: begin src = 2'd2; return K_WRITE; end
      7'b1101111, 7'b1100111: begin src = 2'd3; return K_WRITE; end
      7'b0010011:             begin src = 2'd1; imm = 1'b1; return K_WRITE; end
      7'b0110011:             begin src = 2'd1; return K_WRITE; end
      7'b1100011, 7'b0001111: return K_PC;
      7'b0000011:             return K_LOAD;
      7'b0100011:             return (f3 == 3'b010) ? K_SW : K_STPRE;
      7'b1110011:             return (f3 == 3'b000) ? K_ECALL : K_BAD;
      default:                return K_BAD;
    endcase
  endfunction

  function automatic void evalModel(input int d, output outs_t e, output int np, output int nw,
                                    output int nc, output logic [31:0] ncnt, output bit nl);
    int k, hc;
    logic [1:0] src;
    logic imm;
    bit waiting;
    e = '0;
    np = mPhase[d];
    nl = mLoad[d];
    hc = 0;
    waiting = 1'b0;
    e.halted    = (mPhase[d] == P_HALT);
    e.haltCause = 3'(mCause[d]);
    e.retired   = mCount[d];
    case (mPhase[d])
      P_FETCH: begin
        e.fetchReq = 1'b1;
        if (fetchReady) np = P_EXEC; else waiting = 1'b1;
      end
      P_EXEC: begin
        k = classify(opcode, funct3, src, imm);
        if (errorFlags != 4'd0) hc = 4;
        else case (k)
          K_BADLOW: hc = 3;
          K_BAD:    hc = 2;
          K_ECALL:  if (ecallHalts[d]) hc = 1; else begin e.pcWE = 1'b1; np = P_FETCH; end
          K_WRITE:  begin e.rdWE = 1'b1; e.rdSource = src; e.opImm = imm; e.pcWE = 1'b1; np = P_FETCH; end
          K_PC:     begin e.pcWE = 1'b1; np = P_FETCH; end
          K_LOAD:   begin np = P_ACC; nl = 1'b1; end
          K_SW:     begin np = P_ACC; nl = 1'b0; end
          default:  begin np = P_PRE; nl = 1'b0; end
        endcase
      end
      P_PRE: begin
        e.memReq = 1'b1;
        e.memoryMode = 2'd2;
        if (errorFlags != 4'd0) hc = 4;
        else if (memReady) np = P_ACC;
        else waiting = 1'b1;
      end
      P_ACC: begin
        e.memReq = 1'b1;
        e.memoryMode = mLoad[d] ? 2'd1 : 2'd3;
        if (errorFlags != 4'd0) hc = 4;
        else if (memReady) begin
          e.pcWE = 1'b1;
          e.rdWE = mLoad[d];
          np = P_FETCH;
        end else waiting = 1'b1;
      end
      default: ;
    endcase
    if (waiting && (mWait[d] + 1 >= maxW[d])) hc = 5;
    if (hc != 0) np = P_HALT;
    nw   = (np != mPhase[d]) ? 0 : (waiting ? mWait[d] + 1 : mWait[d]);
    nc   = (hc != 0) ? hc : mCause[d];
    ncnt = e.pcWE ? ((mCount[d] + 32'd1) & cntMask[d]) : mCount[d];
    if (reset) begin
      e.fetchReq = 1'b0; e.memReq = 1'b0; e.rdWE = 1'b0; e.pcWE = 1'b0;
      np = P_FETCH; nw = 0; nc = 0; ncnt = 32'd0; nl = 1'b0;
    end
  endfunction

  outs_t expO, actO;
  always @(negedge clk) begin
    if (modelValid) begin
      for (int d = 0; d < 2; d++) begin
        evalModel(d, expO, pPhase[d], pWait[d], pCause[d], pCount[d], pLoad[d]);
        actO.fetchReq   = frO[d];
        actO.memReq     = mrO[d];
        actO.memoryMode = mmO[d];
        actO.rdWE       = weO[d];
        actO.rdSource   = srcO[d];
        actO.opImm      = immO[d];
        actO.pcWE       = pcO[d];
        actO.halted     = hO[d];
        actO.haltCause  = hcO[d];
        actO.retired    = (d == 0) ? {28'd0, cntA} : cntB;
        if (!expO.rdWE) begin
          expO.rdSource = actO.rdSource;
          expO.opImm    = actO.opImm;
        end
        vectors++;
        if (actO !== expO) begin
          miscompares++;
          $display("FAIL cycle dut%0d @%0t got fr=%b mr=%b mm=%0d we=%b src=%0d imm=%b pc=%b h=%b c=%0d n=%0d expected fr=%b mr=%b mm=%0d we=%b src=%0d imm=%b pc=%b h=%b c=%0d n=%0d",
                   d, $time, actO.fetchReq, actO.memReq, actO.memoryMode, actO.rdWE, actO.rdSource,
                   actO.opImm, actO.pcWE, actO.halted, actO.haltCause, actO.retired,
                   expO.fetchReq, expO.memReq, expO.memoryMode, expO.rdWE, expO.rdSource,
                   expO.opImm, expO.pcWE, expO.halted, expO.haltCause, expO.retired);
        end
      end
    end
  end

  always @(posedge clk) begin
    if (reset && !modelValid) begin
      for (int d = 0; d < 2; d++) begin
        mPhase[d] <= P_FETCH; mWait[d] <= 0; mCause[d] <= 0; mCount[d] <= 32'd0; mLoad[d] <= 1'b0;
      end
      modelValid <= 1'b1;
    end else if (modelValid) begin
      for (int d = 0; d < 2; d++) begin
        mPhase[d] <= pPhase[d]; mWait[d] <= pWait[d]; mCause[d] <= pCause[d];
        mCount[d] <= pCount[d]; mLoad[d] <= pLoad[d];
      end
    end
  end

  task automatic checkLit(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  logic [6:0] tblOp [8] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                           7'b0110011, 7'b0010011, 7'b1100011, 7'b0001111};
  bit         tblWe [8] = '{1, 1, 1, 1, 1, 1, 0, 0};
  logic [2:0] tblSrc[8] = '{3'b100, 3'b100, 3'b110, 3'b110, 3'b010, 3'b011, 3'b000, 3'b000};

  initial begin
    int pcPulses, fetchSeen;
    reset = 1'b1; opcode = 7'b0010011; funct3 = 3'b000; errorFlags = 4'd0;
    fetchReady = 1'b0; memReady = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    fetchReady = 1'b1;
    @(negedge clk);
    checkLit("postResetFetchReq", 32'(frO[0]), 1);
    checkLit("postResetPcWe", 32'(pcO[0]), 0);
    checkLit("postResetCount", 32'(cntA), 0);

    // addi stream: one retire every two cycles
    repeat (10) tick();
    @(negedge clk);
    checkLit("addiCountA", 32'(cntA), 5);
    checkLit("addiCountB", cntB, 5);
    repeat (24) tick();
    @(negedge clk);
    checkLit("wrapCountA", 32'(cntA), 1);
    checkLit("noWrapCountB", cntB, 17);

    for (int i = 0; i < 8; i++) begin
      opcode = tblOp[i];
      tick();
      @(negedge clk);
      checkLit("instrWePc", {30'd0, weO[0], pcO[0]}, {30'd0, tblWe[i], 1'b1});
      if (tblWe[i]) checkLit("instrSrcImm", {29'd0, srcO[0], immO[0]}, {29'd0, tblSrc[i]});
      tick();
    end

    // sb with three stalls in each memory phase
    opcode = 7'b0100011; funct3 = 3'b000;
    pcPulses = 0; fetchSeen = 0;
    for (int c = 0; c < 10; c++) begin
      memReady = (c == 5 || c == 9);
      @(negedge clk);
      pcPulses += int'(pcO[0]);
      if (c > 0) fetchSeen += int'(frO[0]);
      if (c == 2) checkLit("sbPreloadMode", 32'(mmO[0]), 2);
      if (c == 6) checkLit("sbStoreMode", 32'(mmO[0]), 3);
      tick();
    end
    memReady = 1'b0;
    @(negedge clk);
    checkLit("sbBackToFetch", 32'(frO[0]), 1);
    checkLit("sbPcPulses", 32'(pcPulses), 1);
    checkLit("sbNoFetchInside", 32'(fetchSeen), 0);

    // sw goes straight to the access phase
    funct3 = 3'b010; memReady = 1'b1;
    repeat (3) tick();
    // lw completing immediately
    opcode = 7'b0000011;
    tick(); tick();
    @(negedge clk);
    checkLit("lwWe", 32'(weO[0]), 1);
    checkLit("lwSrc", 32'(srcO[0]), 0);
    tick();

    // lw timeout on dutA
    memReady = 1'b0;
    tick(); tick();
    for (int i = 1; i <= 4; i++) begin
      tick();
      @(negedge clk);
      checkLit("lwTimeoutHalted", 32'(hO[0]), (i == 4) ? 1 : 0);
    end
    checkLit("lwTimeoutCause", 32'(hcO[0]), 5);
    memReady = 1'b1;
    tick();
    @(negedge clk);
    checkLit("haltSticky", {28'd0, hO[0], frO[0], mrO[0], pcO[0]}, 32'b1000);
    doReset();

    // reset during a completing access
    memReady = 1'b0;
    tick(); tick();
    memReady = 1'b1; reset = 1'b1;
    @(negedge clk);
    checkLit("resetInFlightPc", 32'(pcO[0]), 0);
    checkLit("resetInFlightMemReq", 32'(mrO[0]), 0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    checkLit("resetInFlightCount", 32'(cntA), 0);
    checkLit("afterResetMemReq", 32'(mrO[0]), 0);
    checkLit("afterResetFetchReq", 32'(frO[0]), 1);

    // error flag beats bad low opcode
    memReady = 1'b0; opcode = 7'b0000000;
    tick();
    errorFlags = 4'b0001;
    @(negedge clk);
    checkLit("errStrobes", {30'd0, weO[0], pcO[0]}, 0);
    tick();
    errorFlags = 4'd0;
    @(negedge clk);
    checkLit("errCauseA", 32'(hcO[0]), 4);
    checkLit("errCauseB", 32'(hcO[1]), 4);
    doReset();

    opcode = 7'b0000001;
    tick(); tick();
    @(negedge clk);
    checkLit("badLowCause", 32'(hcO[0]), 3);
    doReset();

    opcode = 7'b0101011;
    tick(); tick();
    @(negedge clk);
    checkLit("badOpCause", 32'(hcO[1]), 2);
    doReset();

    // error during store preload
    opcode = 7'b0100011; funct3 = 3'b001;
    tick(); tick();
    errorFlags = 4'b0100;
    tick();
    errorFlags = 4'd0;
    @(negedge clk);
    checkLit("preloadErrCause", 32'(hcO[0]), 4);
    doReset();

    // error coincides with timeout cycle: error wins
    opcode = 7'b0000011; funct3 = 3'b010;
    tick(); tick();
    repeat (3) tick();
    errorFlags = 4'b1000;
    tick();
    errorFlags = 4'd0;
    @(negedge clk);
    checkLit("errOverTimeout", 32'(hcO[0]), 4);
    doReset();

    // fetch timeout on dutA only
    fetchReady = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    checkLit("fetchTimeoutA", {29'd0, hO[0], hcO[0][1:0]}, {29'd0, 3'b101});
    checkLit("fetchWaitB", 32'(hO[1]), 0);
    fetchReady = 1'b1;
    doReset();

    // ecall: halts dutA, retires on dutB
    opcode = 7'b1110011; funct3 = 3'b000;
    tick(); tick();
    @(negedge clk);
    checkLit("ecallHaltA", {28'd0, hO[0], hcO[0]}, 32'b1001);
    checkLit("ecallRetireB", cntB, 1);
    opcode = 7'b0010011;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    checkLit("resetFromHaltFetchReq", 32'(frO[0]), 1);
    checkLit("resetFromHaltCause", 32'(hcO[0]), 0);
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/stall_aware_control.md
STALL_AWARE_CONTROL -- requirements
Module: stall_aware_control

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 15: maximum wait cycles in any wait state before timeout halt; legal range 1..255.
REQ-002 SHALL have parameter NUM_ERR, default 4: width of external error flag vector.
REQ-003 SHALL have parameter COUNT_W, default 32: width of retired-instruction counter.
REQ-004 SHALL have parameter ECALL_HALTS, default 1: 1 = ecall/ebreak halts core; 0 = ecall/ebreak retires as nop.
REQ-005 SHALL have ports, one per line, clock and reset first:
 clock  in  1  single clock, all state on posedge
 reset  in  1  synchronous, active-high
 opcode  in  7  current instruction opcode
 funct3  in  3  current instruction funct3
 errorFlags  in  NUM_ERR  datapath error flags, any bit high = fatal
 fetchReady  in  1  instruction memory returned instruction this cycle
 memReady  in  1  data memory completed current access this cycle
 fetchReq  out  1  instruction fetch request
 memReq  out  1  data memory request
 memoryMode  out  2  0 NOP, 1 LOAD, 2 STORE_PRELOAD, 3 STORE
 rdWriteEnable  out  1  register file write strobe
 rdSource  out  2  0 memory, 1 ALU, 2 immediate former, 3 branch ALU
 opImm  out  1  ALU OP-IMM select
 programCounterWriteEnable  out  1  PC update strobe (one per retired instruction)
 halted  out  1  core halted
 haltCause  out  3  0 none, 1 ecall/ebreak, 2 bad opcode, 3 bad low opcode, 4 error flag, 5 timeout
 retiredCount  out  COUNT_W  instructions retired since reset
REQ-006 Reset SHALL be synchronous and active-high on a single clock; polarity and synchronicity are fixed.

Function
REQ-007 SHALL implement states FETCH, EXECUTE, MEM_PRELOAD, MEM_ACCESS, HALT; state register updates on posedge clock only.
REQ-008 FETCH: fetchReq=1; fetchReady=1 -> EXECUTE next cycle; else stay.
REQ-009 EXECUTE: decode opcode[6:2]; lui/auipc (rdSource=2), jal/jalr (rdSource=3), OP-IMM (rdSource=1, opImm=1), OP (rdSource=1, opImm=0): rdWriteEnable=1, programCounterWriteEnable=1 -> FETCH.
REQ-010 EXECUTE: branch and fence: rdWriteEnable=0, programCounterWriteEnable=1 -> FETCH.
REQ-011 EXECUTE: load -> MEM_ACCESS; store with funct3=010 (sw) -> MEM_ACCESS; other stores -> MEM_PRELOAD; no outputs strobed.
REQ-012 MEM_PRELOAD: memReq=1, memoryMode=2; memReady=1 -> MEM_ACCESS.
REQ-013 MEM_ACCESS: memReq=1, memoryMode=1 for load, 3 for store; on memReady=1 same cycle: programCounterWriteEnable=1, and for load rdWriteEnable=1, rdSource=0; -> FETCH.
REQ-014 Outputs SHALL be combinational from current state, opcode, funct3 and ready inputs; strobes SHALL be 0 in any state/condition not listed; memoryMode=0 outside memory states.
REQ-015 A wait counter SHALL clear on every state change and increment each cycle in FETCH, MEM_PRELOAD, MEM_ACCESS without ready; reaching MAX_WAIT without ready -> HALT, cause 5.
REQ-016 In EXECUTE: opcode[1:0]!=11 -> HALT cause 3; unknown opcode[6:2] -> HALT cause 2; ecall/ebreak with ECALL_HALTS=1 -> HALT cause 1, with ECALL_HALTS=0 retires as nop.
REQ-017 Any errorFlags bit high in EXECUTE, MEM_PRELOAD or MEM_ACCESS -> HALT cause 4.
REQ-018 Simultaneous halt conditions SHALL use priority 4 > 3 > 2 > 1 > 5; an instruction causing a halt SHALL NOT strobe rdWriteEnable or programCounterWriteEnable.
REQ-019 HALT is sticky until reset: halted=1, haltCause held, all requests and strobes 0.
REQ-020 retiredCount SHALL increment by 1 on each cycle with programCounterWriteEnable=1, wrapping from 2^COUNT_W-1 to 0.

Reset
REQ-021 reset=1 at posedge SHALL force state FETCH, wait counter 0, haltCause 0, halted 0, retiredCount 0, overriding all other events including HALT and in-flight memory access.
REQ-022 During the reset cycle and the following cycle, rdWriteEnable, programCounterWriteEnable and memReq SHALL be 0; fetchReq=1 from the first cycle after reset.

Verification
REQ-023 addi (0010011), fetchReady=1 every cycle -> alternating FETCH/EXECUTE, one programCounterWriteEnable per 2 cycles, retiredCount=5 after 10 cycles.
REQ-024 sb (0100011, funct3 000), memReady low 3 cycles in each phase -> memoryMode 2 then 3, single PC strobe, total 10 cycles FETCH-to-FETCH.
REQ-025 lw, MAX_WAIT=4, memReady held 0 -> halted=1, haltCause=5 exactly 4 cycles after entering MEM_ACCESS, no rdWriteEnable.
REQ-026 opcode 0000000 with errorFlags=0001 in EXECUTE -> haltCause=4 (priority over bad low opcode), no strobes.
REQ-027 ecall with ECALL_HALTS=0 -> retires, retiredCount+1; with ECALL_HALTS=1 -> haltCause=1; reset asserted in HALT -> next cycle fetchReq=1, haltCause=0.
REQ-028 COUNT_W=4, 17 retired instructions -> retiredCount=1.
